serial_subtractor: RTL

Bit-serial unsigned/two's-complement subtractor, the inverse-operation companion to the team's combinational 1-bit full adder. Loads two WIDTH-bit operands on a start handshake and computes diff = a − b one bit per clock, LSB first, through a single 1-bit full-subtractor cell with a registered borrow. It trades area for latency and sits behind the TinyTapeout top wrapper: ui_in/uio_in drive operands and control, uo_out carries the result and flags.

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first through a
// full-subtractor cell with a registered borrow. Define SERIAL_SUB_OVF_EN for the ovf flag.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             brw_q;
    logic             brw_d;
    logic             bit_d;
    logic             busy_q;
    logic             done_q;
    logic             borrow_q;
    logic             last_bit;

    // One full-subtractor cell shared across all bit positions.
    always_comb begin
        bit_d    = a_q[0] ^ b_q[0] ^ brw_q;
        brw_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
        sr_d     = {bit_d, sr_q[WIDTH-1:1]};
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if (state_q == S_RUN && last_bit) begin
            ovf_q <= (a_msb_q != b_msb_q) & (bit_d != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    brw_q <= brw_d;
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CW'(1);
                    // diff/borrow_out are published only once all bits are in.
                    if (last_bit) begin
                        diff_q   <= sr_d;
                        borrow_q <= brw_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
